// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the handshaked pipeline stage registers.
package pipe_skid_stage_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int LANES_MAX  = 4;

    // addi x0,x0,0 -- driven on every lane that carries no instruction
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Default-width fetch bundle shared with the later stage boundaries
    // (ID/EX etc.). Parameterised stages build a local equivalent of this.
    typedef struct packed {
        logic                                 valid;
        logic [PC_W_DEF-1:0]                  pc;
        logic [LANES_MAX-1:0][INST_W_DEF-1:0] inst;
        logic [LANES_MAX-1:0]                 lane_valid;
    } bundle_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream/downstream handshake bundle for a pipeline stage register.
// slave = the stage register's view, master = the surrounding pipeline's view.
interface pipe_skid_stage_if
    import pipe_skid_stage_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int LANES  = 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [PC_W-1:0]         in_pc;
    logic [LANES*INST_W-1:0] in_inst;
    logic [LANES-1:0]        in_lane_valid;

    logic                    out_valid;
    logic                    out_ready;
    logic [PC_W-1:0]         out_pc;
    logic [LANES*INST_W-1:0] out_inst;
    logic [LANES-1:0]        out_lane_valid;

    modport slave (
        input  in_valid, in_pc, in_inst, in_lane_valid, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_lane_valid
    );

    modport master (
        output in_valid, in_pc, in_inst, in_lane_valid, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_lane_valid
    );
endinterface

// File: rtl/pipe_skid_stage_fmt.sv
// Output formatter for a stored bundle: zeroes PC/valids of an empty entry
// and substitutes NOP on every lane that is not valid.
module pipe_bundle_fmt
    import pipe_skid_stage_pkg::*;
#(
    parameter int                PC_W   = PC_W_DEF,
    parameter int                INST_W = INST_W_DEF,
    parameter int                LANES  = 1,
    parameter logic [INST_W-1:0] NOP    = INST_W'(NOP_INSN)
) (
    input  logic                    valid,
    input  logic [PC_W-1:0]         pc,
    input  logic [LANES*INST_W-1:0] inst,
    input  logic [LANES-1:0]        lane_valid,
    output logic [PC_W-1:0]         o_pc,
    output logic [LANES*INST_W-1:0] o_inst,
    output logic [LANES-1:0]        o_lane_valid
);
    assign o_pc         = valid ? pc : '0;
    assign o_lane_valid = valid ? lane_valid : '0;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign o_inst[gi*INST_W +: INST_W] =
            o_lane_valid[gi] ? inst[gi*INST_W +: INST_W] : NOP;
    end
endmodule

// File: rtl/pipe_skid_stage.sv
// IF/ID-style stage register with a 2-entry skid buffer: the main entry
// drives the outputs, the skid entry catches the one bundle that can arrive
// while downstream stalls, so in_ready is purely a flop output.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                PC_W   = PC_W_DEF,
    parameter int                INST_W = INST_W_DEF,
    parameter int                LANES  = 1,
    parameter logic [INST_W-1:0] NOP    = INST_W'(NOP_INSN),
    parameter int                CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_skid_stage_if.slave      bus,
    input  logic                  stall,
    input  logic                  flush,
    output logic [CNT_W-1:0]      bp_cnt
);
    typedef struct packed {
        logic                    valid;
        logic [PC_W-1:0]         pc;
        logic [LANES*INST_W-1:0] inst;
        logic [LANES-1:0]        lane_valid;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           incoming;
    logic [CNT_W-1:0] bp_cnt_q, bp_cnt_d;
    logic             eff_ready;
    logic             acc_in;
    logic             acc_out;

    // Handshake qualifiers and next-state of both entries and the counter
    always_comb begin
        incoming.valid      = 1'b1;
        incoming.pc         = bus.in_pc;
        incoming.inst       = bus.in_inst;
        incoming.lane_valid = bus.in_lane_valid;

        // An all-empty bundle is accepted but never stored.
        eff_ready = bus.out_ready & ~stall;
        acc_in    = bus.in_valid & ~skid_q.valid & (|bus.in_lane_valid);
        acc_out   = main_q.valid & eff_ready;

        main_d   = main_q;
        skid_d   = skid_q;
        bp_cnt_d = bp_cnt_q;

        if (main_q.valid && !eff_ready && (bp_cnt_q != {CNT_W{1'b1}})) begin
            bp_cnt_d = bp_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            // Anything delivered this edge already belongs to downstream.
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!main_q.valid) begin
            if (acc_in) begin
                main_d = incoming;
            end
        end else if (acc_out) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (acc_in) begin
                main_d = incoming;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (acc_in) begin
            skid_d = incoming;
        end
    end

    // State registers; reset wins over flush and every transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            bp_cnt_q <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            bp_cnt_q <= bp_cnt_d;
        end
    end

    assign bus.in_ready  = ~skid_q.valid;
    assign bus.out_valid = main_q.valid;
    assign bp_cnt        = bp_cnt_q;

    pipe_bundle_fmt #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .LANES  (LANES),
        .NOP    (NOP)
    ) u_fmt (
        .valid        (main_q.valid),
        .pc           (main_q.pc),
        .inst         (main_q.inst),
        .lane_valid   (main_q.lane_valid),
        .o_pc         (bus.out_pc),
        .o_inst       (bus.out_inst),
        .o_lane_valid (bus.out_lane_valid)
    );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: directed steps followed by random traffic, all
// compared cycle by cycle against a FIFO-occupancy reference model.
module tb_pipe_skid_stage;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int LANES  = 2;
    localparam int CNT_W  = 4;
    localparam logic [31:0] NOPV = 32'h0000_0013;
    localparam int BP_MAX = 15;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [1:0]  lv;
    } ent_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    logic [CNT_W-1:0] bp_cnt;

    pipe_skid_stage_if #(.PC_W(PC_W), .INST_W(INST_W), .LANES(LANES)) bus ();

    pipe_skid_stage #(
        .PC_W(PC_W), .INST_W(INST_W), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .stall  (stall),
        .flush  (flush),
        .bp_cnt (bp_cnt)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    int   exp_bp = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model, then advance model and DUT one edge.
    task automatic step();
        logic [63:0] e_pc, e_inst;
        logic [1:0]  e_lv;
        logic        e_ov, eff, a_in, a_out;
        ent_t        n;
        e_ov = (q.size() > 0);
        e_pc = e_ov ? q[0].pc : 64'd0;
        e_lv = e_ov ? q[0].lv : 2'b00;
        for (int i = 0; i < LANES; i++)
            e_inst[i*32 +: 32] = e_lv[i] ? q[0].inst[i*32 +: 32] : NOPV;
        chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
        chk("out_valid", 128'(bus.out_valid), 128'(e_ov));
        chk("out_pc", 128'(bus.out_pc), 128'(e_pc));
        chk("out_lane_valid", 128'(bus.out_lane_valid), 128'(e_lv));
        chk("out_inst", 128'(bus.out_inst), 128'(e_inst));
        chk("bp_cnt", 128'(bp_cnt), 128'(exp_bp));

        eff   = bus.out_ready && !stall;
        a_out = e_ov && eff;
        a_in  = bus.in_valid && (q.size() < 2) && (bus.in_lane_valid != 2'b00);
        if (rst) begin
            exp_bp = 0;
            q.delete();
        end else begin
            if (e_ov && !eff && exp_bp < BP_MAX) exp_bp++;
            if (flush) begin
                q.delete();
            end else begin
                if (a_out) void'(q.pop_front());
                if (a_in) begin
                    n.pc = bus.in_pc; n.inst = bus.in_inst; n.lv = bus.in_lane_valid;
                    q.push_back(n);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [1:0] lv);
        bus.in_valid      = v;
        bus.in_pc         = pc;
        bus.in_lane_valid = lv;
        bus.in_inst       = {$urandom, $urandom};
    endtask

    initial begin
        int saved_bp;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'd0, 2'b00);
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        // 1: idle after reset
        step();
        chk("reset_out_inst", 128'(bus.out_inst), 128'({NOPV, NOPV}));
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));

        // 2: streaming without bubbles
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h1000, 2'b11); step();
        drive(1'b1, 64'h1008, 2'b11); step();
        chk("stream_pc0", 128'(bus.out_pc), 128'(64'h1008));
        drive(1'b1, 64'h1010, 2'b11); step();
        drive(1'b0, 64'h0, 2'b00); step();
        step();

        // 3: backpressure into the skid entry
        drive(1'b1, 64'h1000, 2'b11); step();
        stall = 1'b1;
        saved_bp = exp_bp;
        drive(1'b1, 64'h1008, 2'b11); step();
        chk("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
        drive(1'b0, 64'h0, 2'b00); step();
        step();
        chk("bp_cnt_3", 128'(bp_cnt), 128'(saved_bp + 3));
        stall = 1'b0;
        step();
        chk("bp_second_pc", 128'(bus.out_pc), 128'(64'h1008));
        step();
        step();

        // 4: flush with both entries full and a bundle offered
        stall = 1'b1;
        drive(1'b1, 64'h3000, 2'b11); step();
        drive(1'b1, 64'h3008, 2'b11); step();
        stall = 1'b0; flush = 1'b1;
        drive(1'b1, 64'h2000, 2'b11);
        saved_bp = int'(bp_cnt);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 2'b00);
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_bp_same", 128'(bp_cnt), 128'(saved_bp));
        step();

        // 5: partial and empty bundles
        drive(1'b1, 64'h4000, 2'b01); step();
        chk("partial_lane1_nop", 128'(bus.out_inst[63:32]), 128'(NOPV));
        drive(1'b1, 64'h4008, 2'b00); step();
        drive(1'b0, 64'h0, 2'b00); step();
        step();

        // 6: counter saturation, then reset mid-hold
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h5000, 2'b10); step();
        drive(1'b0, 64'h0, 2'b00);
        for (int i = 0; i < 20; i++) step();
        chk("bp_saturated", 128'(bp_cnt), 128'(15));
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_bp", 128'(bp_cnt), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {32'd0, $urandom}, 2'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
